// File: rtl/bitlen_serializer_16bit_pkg.sv
// Shared constants and state type for the bit-length serializer.
// N elements per word, IDX_W-bit length index, two-state FSM enum.
package bitlen_pkg;

    localparam int N     = 16;
    localparam int IDX_W = $clog2(N);

    typedef enum logic {
        IDLE,
        SHIFT
    } bls_state_t;

endpackage

// File: rtl/bitlen_serializer_16bit_if.sv
// Load/serial-out bundle for the bit-length serializer.
// master: source + sink side (drives data_i, len_i, in_valid_i, out_ready_i).
// slave:  serializer side (drives in_ready_o, bit_o, out_valid_o, last_o).
interface bitlen_serializer_16bit_if;
    import bitlen_pkg::*;

    logic             data_i [0:N-1];
    logic [IDX_W-1:0] len_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             bit_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             last_o;

    modport master (
        output data_i,
        output len_i,
        output in_valid_i,
        output out_ready_i,
        input  in_ready_o,
        input  bit_o,
        input  out_valid_o,
        input  last_o
    );

    modport slave (
        input  data_i,
        input  len_i,
        input  in_valid_i,
        input  out_ready_i,
        output in_ready_o,
        output bit_o,
        output out_valid_o,
        output last_o
    );

endinterface

// File: rtl/bitlen_serializer_16bit_cnt.sv
// Loadable down-counter with synchronous reset; saturates at zero.
// Ports: clk_i, rst_i, load (takes d), en (decrement), q, zero_o (q==0).
module cnt_down_n #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         zero_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en && (q != '0)) begin
            q <= q - 1'b1;
        end
    end

    assign zero_o = (q == '0);

endmodule

// File: rtl/bitlen_serializer_16bit.sv
// Sends bits len_i..0 of a loaded 16-element vector, highest index first.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport).
module bitlen_serializer_16bit
    import bitlen_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    bitlen_serializer_16bit_if.slave  bus
);

    bls_state_t       state_q;
    bls_state_t       state_d;
    logic             load;
    logic             dec;
    logic             in_ready;
    logic             out_valid;
    logic [IDX_W-1:0] idx;
    logic             idx_zero;
    logic             data_q [0:N-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        dec       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid_i) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                if (bus.out_ready_i) begin
                    if (idx_zero) begin
                        state_d = IDLE;
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    cnt_down_n #(
        .W (IDX_W)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load   (load),
        .en     (dec),
        .d      (bus.len_i),
        .q      (idx),
        .zero_o (idx_zero)
    );

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (rst_i) begin
                data_q[i] <= 1'b0;
            end else if (load) begin
                data_q[i] <= bus.data_i[i];
            end
        end
    end

    // Gate with state so idle outputs stay 0 regardless of leftover idx/data.
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.bit_o       = out_valid & data_q[idx];
    assign bus.last_o      = out_valid & idx_zero;

endmodule

// File: tb/tb_bitlen_serializer_16bit.sv
// Self-checking bench for bitlen_serializer_16bit: vector table,
// hand sequences and randomized traffic against a bit-queue model.
module tb_bitlen_serializer_16bit;
    import bitlen_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bitlen_serializer_16bit_if bus();

    bitlen_serializer_16bit u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  len;
        logic [15:0] seq;
        int          n;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    bit   model_q[$];
    logic o_valid, o_bit, o_last, o_ready;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // One clock: drive at start, compare at negedge, update model at posedge.
    task automatic drive(input logic r, input logic iv, input logic ordy,
                         input logic [15:0] d, input logic [3:0] l);
        int sz;
        rst             = r;
        bus.in_valid_i  = iv;
        bus.out_ready_i = ordy;
        bus.len_i       = l;
        for (int i = 0; i < N; i++) bus.data_i[i] = d[i];
        @(negedge clk);
        o_valid = bus.out_valid_o;
        o_bit   = bus.bit_o;
        o_last  = bus.last_o;
        o_ready = bus.in_ready_o;
        sz = model_q.size();
        check("in_ready", 32'(o_ready), 32'(sz == 0));
        check("out_valid", 32'(o_valid), 32'(sz != 0));
        if (sz != 0) begin
            check("bit", 32'(o_bit), 32'(model_q[0]));
            check("last", 32'(o_last), 32'(sz == 1));
        end else begin
            check("idle_bit", 32'(o_bit), 32'd0);
            check("idle_last", 32'(o_last), 32'd0);
        end
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else if (sz != 0 && ordy) begin
            void'(model_q.pop_front());
        end else if (sz == 0 && iv) begin
            for (int j = int'(l); j >= 0; j--) model_q.push_back(d[j]);
        end
        #1;
    endtask

    task automatic run_word(input logic [15:0] d, input logic [3:0] l,
                            output logic [15:0] seq, output int n);
        seq = '0;
        n   = 0;
        drive(1'b0, 1'b1, 1'b1, d, l);
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, 1'b0, 1'b1, 16'($urandom), 4'($urandom));
            if (o_valid) begin
                if (n < 16) seq[n] = o_bit;
                n++;
                if (o_last) break;
            end
        end
        drive(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
    endtask

    vec_t        vecs [6];
    logic [15:0] seq;
    int          n;
    int          loads, lasts;
    int          pat [7];

    initial begin
        vecs[0] = '{16'h0029, 4'd5,  16'h0025, 6};
        vecs[1] = '{16'h0001, 4'd0,  16'h0001, 1};
        vecs[2] = '{16'hFFFF, 4'd15, 16'hFFFF, 16};
        vecs[3] = '{16'h000D, 4'd3,  16'h000B, 4};
        vecs[4] = '{16'h8003, 4'd15, 16'hC001, 16};
        vecs[5] = '{16'h0000, 4'd7,  16'h0000, 8};
        pat = '{1, 0, 0, 1, 0, 1, 1};

        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.len_i       = '0;
        for (int i = 0; i < N; i++) bus.data_i[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        check("reset_in_ready", 32'(o_ready), 32'd1);
        check("reset_out_valid", 32'(o_valid), 32'd0);

        foreach (vecs[v]) begin
            run_word(vecs[v].data, vecs[v].len, seq, n);
            check($sformatf("vec%0d_seq", v), 32'(seq), 32'(vecs[v].seq));
            check($sformatf("vec%0d_count", v), 32'(n), 32'(vecs[v].n));
        end

        // Stall pattern with a mid-word load request that must be ignored.
        drive(1'b0, 1'b1, 1'b1, 16'h000D, 4'd3);
        seq = '0;
        n   = 0;
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, (c == 2), pat[c][0], 16'hFFF0, 4'd9);
            if (o_valid && pat[c][0]) begin
                seq[n] = o_bit;
                n++;
            end
        end
        check("stall_seq", 32'(seq), 32'h000B);
        check("stall_count", 32'(n), 32'd4);
        drive(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
        check("stall_done_idle", 32'(o_ready), 32'd1);

        // Reset after 2 of 8 bits abandons the word.
        drive(1'b0, 1'b1, 1'b1, 16'hA5C3, 4'd7);
        drive(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
        drive(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'd15);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        check("rst_mid_ready", 32'(o_ready), 32'd1);
        check("rst_mid_bit", 32'(o_bit), 32'd0);
        check("rst_mid_last", 32'(o_last), 32'd0);
        run_word(vecs[0].data, vecs[0].len, seq, n);
        check("after_rst_seq", 32'(seq), 32'h0025);
        check("after_rst_count", 32'(n), 32'd6);

        // Back-to-back words with in_valid held high.
        loads = 0;
        lasts = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b1, 1'b1, 16'h0002, 4'd1);
            if (o_ready) loads++;
            if (o_valid && o_last) lasts++;
        end
        check("b2b_loads", 32'(loads), 32'd4);
        check("b2b_lasts", 32'(lasts), 32'd4);

        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 59) == 0),
                  1'($urandom), ($urandom_range(0, 3) != 0),
                  16'($urandom), 4'($urandom));
        end
        for (int c = 0; c < 20; c++) drive(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
